dds_gen: RTL and testbench

Parametrised direct digital synthesis generator and next generation of the team's DDS phase-accumulator block. It accumulates a frequency tuning word and adds a phase offset. It shapes the result into square, sawtooth or triangle samples with a registered output pipeline. Configuration arrives through a valid/ready handshake with optional glitch-free update at period wrap, and the block feeds the DAC/sample path.

---
 rtl/dds_pkg.sv | 19 +
 rtl/dds_wave_shaper.sv | 44 ++++
 rtl/dds_gen.sv | 160 ++++++++++++++++
 tb/tb_dds_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dds_pkg                                                |
// | Description : Shared types for the DDS generator: waveform-mode      |
// |               encoding used by dds_gen and dds_wave_shaper.          |
// | Ports       : none (package)                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dds_pkg;

   typedef enum logic [1:0] {
      MODE_SQUARE = 2'd0,
      MODE_SAW    = 2'd1,
      MODE_TRI    = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_t;

endpackage : dds_pkg
`default_nettype wire

// File: rtl/dds_wave_shaper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dds_wave_shaper                                        |
// | Description : Combinational phase-to-amplitude shaper. Turns a phase |
// |               address into a square, sawtooth or triangle sample.    |
// | Ports       : mode   - waveform select                               |
// |               phase  - PHASE_W-bit phase address                     |
// |               sample - OUT_W-bit amplitude                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dds_wave_shaper
   import dds_pkg::*;
#(
   parameter int PHASE_W = 11,
   parameter int OUT_W   = 8
) (
   input  mode_t              mode,
   input  logic [PHASE_W-1:0] phase,
   output logic [OUT_W-1:0]   sample
);

   logic             w_msb;
   logic [OUT_W-1:0] w_tri;
   logic             w_unused_phase;

   assign w_msb = phase[PHASE_W-1];
   // Triangle folds the lower half-period: the bits just below the MSB
   // ramp up, and are inverted in the second half to ramp back down.
   assign w_tri = phase[PHASE_W-2 -: OUT_W];
   // Low phase bits are not needed by any waveform at this sample width.
   assign w_unused_phase = ^phase;

   always_comb begin
      sample = '0;
      case (mode)
         MODE_SQUARE: sample = w_msb ? '0 : '1;
         MODE_SAW:    sample = phase[PHASE_W-1 -: OUT_W];
         MODE_TRI:    sample = w_msb ? ~w_tri : w_tri;
         default:     sample = '0;
      endcase
   end

endmodule : dds_wave_shaper
`default_nettype wire

// File: rtl/dds_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dds_gen                                                |
// | Description : Direct digital synthesis generator. Phase accumulator  |
// |               with phase offset, waveform shaping and a two-stage    |
// |               registered output pipeline. Configuration is taken via |
// |               valid/ready into shadow registers and applied either   |
// |               on the next cycle or glitch-free at accumulator wrap.  |
// | Ports       : clk, rst         - clock, synchronous active-high reset|
// |               en               - accumulate enable                   |
// |               cfg_valid/ready  - configuration handshake             |
// |               cfg_k/p/mode     - tuning word, phase offset, waveform |
// |               wave_valid       - wave_out holds a new sample         |
// |               wave_out         - shaped sample                       |
// |               sq_out           - phase MSB, aligned with wave_out    |
// |               wrap_pulse       - sample follows an accumulator wrap  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dds_gen
   import dds_pkg::*;
#(
   parameter int ACC_W       = 32,
   parameter int PHASE_W     = 11,
   parameter int OUT_W       = 8,
   parameter int SYNC_UPDATE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [ACC_W-1:0]   cfg_k,
   input  logic [PHASE_W-1:0] cfg_p,
   input  logic [1:0]         cfg_mode,
   output logic               wave_valid,
   output logic [OUT_W-1:0]   wave_out,
   output logic               sq_out,
   output logic               wrap_pulse
);

   // Accumulator and active configuration
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   r_k_act;
   logic [PHASE_W-1:0] r_p_act;
   mode_t              r_mode_act;
   // Shadow configuration waiting to be applied
   logic [ACC_W-1:0]   r_k_shd;
   logic [PHASE_W-1:0] r_p_shd;
   mode_t              r_mode_shd;
   logic               r_pending;
   // Marks that the current r_acc value was produced by a wrapping add
   logic               r_wrap;
   // Pipeline stage 1
   logic [PHASE_W-1:0] r_s1_phase;
   mode_t              r_s1_mode;
   logic               r_s1_wrap;
   logic               r_s1_en;

   logic [ACC_W:0]     w_sum;
   logic               w_carry;
   logic               w_accept;
   logic               w_apply;
   logic [PHASE_W-1:0] w_phase;
   logic [OUT_W-1:0]   w_sample;

   assign w_sum    = {1'b0, r_acc} + {1'b0, r_k_act};
   assign w_carry  = en && w_sum[ACC_W];
   assign cfg_ready = !r_pending && !rst;
   assign w_accept = cfg_valid && cfg_ready;
   assign w_phase  = r_acc[ACC_W-1 -: PHASE_W] + r_p_act;

   generate
      if (SYNC_UPDATE != 0) begin : g_sync_apply
         // Swap only at a period boundary. A stopped or zero-step
         // accumulator never wraps, so those cases apply immediately.
         assign w_apply = r_pending && (w_carry || !en || (r_k_act == '0));
      end else begin : g_next_apply
         assign w_apply = r_pending;
      end
   endgenerate

   // Configuration handshake and apply. Accept and apply are mutually
   // exclusive because cfg_ready is low whenever a config is pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_k_shd    <= '0;
         r_p_shd    <= '0;
         r_mode_shd <= MODE_SQUARE;
         r_pending  <= 1'b0;
         r_k_act    <= '0;
         r_p_act    <= '0;
         r_mode_act <= MODE_SQUARE;
      end else if (w_accept) begin
         r_k_shd    <= cfg_k;
         r_p_shd    <= cfg_p;
         r_mode_shd <= mode_t'(cfg_mode);
         r_pending  <= 1'b1;
      end else if (w_apply) begin
         r_k_act    <= r_k_shd;
         r_p_act    <= r_p_shd;
         r_mode_act <= r_mode_shd;
         r_pending  <= 1'b0;
      end
   end

   // Phase accumulator. The wrap flag travels with the value it describes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc  <= '0;
         r_wrap <= 1'b0;
      end else begin
         if (en) begin
            r_acc <= w_sum[ACC_W-1:0];
         end
         r_wrap <= w_carry;
      end
   end

   // Stage 1: phase address and its qualifiers. Advances even when en is
   // low so the last sample repeats with wave_valid deasserted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_phase <= '0;
         r_s1_mode  <= MODE_SQUARE;
         r_s1_wrap  <= 1'b0;
         r_s1_en    <= 1'b0;
      end else begin
         r_s1_phase <= w_phase;
         r_s1_mode  <= r_mode_act;
         r_s1_wrap  <= r_wrap;
         r_s1_en    <= en;
      end
   end

   dds_wave_shaper #(
      .PHASE_W (PHASE_W),
      .OUT_W   (OUT_W)
   ) u_shaper (
      .mode   (r_s1_mode),
      .phase  (r_s1_phase),
      .sample (w_sample)
   );

   // Stage 2: registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         wave_out   <= '0;
         sq_out     <= 1'b0;
         wrap_pulse <= 1'b0;
         wave_valid <= 1'b0;
      end else begin
         wave_out   <= w_sample;
         sq_out     <= r_s1_phase[PHASE_W-1];
         wrap_pulse <= r_s1_wrap;
         wave_valid <= r_s1_en;
      end
   end

endmodule : dds_gen
`default_nettype wire

// File: tb/tb_dds_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dds_gen                                             |
// | Description : Self-checking bench for dds_gen. One instance with     |
// |               next-cycle config update, one with update at wrap.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_dds_gen;

   localparam logic [31:0] C_K1 = 32'h1000_0000;
   localparam logic [31:0] C_K2 = 32'h2000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: SYNC_UPDATE = 0
   logic        rst0 = 1'b1, en0 = 1'b0, cfg_valid0 = 1'b0;
   logic        cfg_ready0;
   logic [31:0] cfg_k0 = '0;
   logic [10:0] cfg_p0 = '0;
   logic [1:0]  cfg_mode0 = '0;
   logic        wave_valid0, sq_out0, wrap_pulse0;
   logic [7:0]  wave_out0;

   // Instance 1: SYNC_UPDATE = 1
   logic        rst1 = 1'b1, en1 = 1'b0, cfg_valid1 = 1'b0;
   logic        cfg_ready1;
   logic [31:0] cfg_k1 = '0;
   logic [10:0] cfg_p1 = '0;
   logic [1:0]  cfg_mode1 = '0;
   logic        wave_valid1, sq_out1, wrap_pulse1;
   logic [7:0]  wave_out1;

   dds_gen #(.ACC_W(32), .PHASE_W(11), .OUT_W(8), .SYNC_UPDATE(0)) dut0 (
      .clk(clk), .rst(rst0), .en(en0), .cfg_valid(cfg_valid0), .cfg_ready(cfg_ready0),
      .cfg_k(cfg_k0), .cfg_p(cfg_p0), .cfg_mode(cfg_mode0), .wave_valid(wave_valid0),
      .wave_out(wave_out0), .sq_out(sq_out0), .wrap_pulse(wrap_pulse0)
   );

   dds_gen #(.ACC_W(32), .PHASE_W(11), .OUT_W(8), .SYNC_UPDATE(1)) dut1 (
      .clk(clk), .rst(rst1), .en(en1), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
      .cfg_k(cfg_k1), .cfg_p(cfg_p1), .cfg_mode(cfg_mode1), .wave_valid(wave_valid1),
      .wave_out(wave_out1), .sq_out(sq_out1), .wrap_pulse(wrap_pulse1)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full period of 16 samples at K = 0x1000_0000, first sample in the MSBs.
   typedef struct packed {
      logic [1:0]   mode;
      logic [10:0]  p;
      logic [127:0] exp_wave;
      logic [15:0]  exp_sq;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{mode: 2'd1, p: 11'h000, exp_wave: 128'h00102030_40506070_8090A0B0_C0D0E0F0, exp_sq: 16'h00FF};
      vecs[1] = '{mode: 2'd2, p: 11'h000, exp_wave: 128'h00204060_80A0C0E0_FFDFBF9F_7F5F3F1F, exp_sq: 16'h00FF};
      vecs[2] = '{mode: 2'd0, p: 11'h000, exp_wave: 128'hFFFFFFFF_FFFFFFFF_00000000_00000000, exp_sq: 16'h00FF};
      vecs[3] = '{mode: 2'd0, p: 11'h400, exp_wave: 128'h00000000_00000000_FFFFFFFF_FFFFFFFF, exp_sq: 16'hFF00};
      vecs[4] = '{mode: 2'd1, p: 11'h400, exp_wave: 128'h8090A0B0_C0D0E0F0_00102030_40506070, exp_sq: 16'hFF00};
      vecs[5] = '{mode: 2'd3, p: 11'h000, exp_wave: 128'h0, exp_sq: 16'h00FF};

      // ---------------- Reset behaviour (both instances) ----------------
      rst0 = 1'b1; en0 = 1'b1; cfg_valid0 = 1'b1; cfg_k0 = C_K1; cfg_mode0 = 2'd1;
      rst1 = 1'b1; en1 = 1'b1; cfg_valid1 = 1'b1; cfg_k1 = C_K1; cfg_mode1 = 2'd1;
      repeat (3) step();
      check("rst wave_out",   32'(wave_out0),   32'h0);
      check("rst sq_out",     32'(sq_out0),     32'h0);
      check("rst wave_valid", 32'(wave_valid0), 32'h0);
      check("rst wrap_pulse", 32'(wrap_pulse0), 32'h0);
      check("rst cfg_ready",  32'(cfg_ready0),  32'h0);
      check("rst cfg_ready1", 32'(cfg_ready1),  32'h0);
      rst0 = 1'b0; cfg_valid0 = 1'b0; en0 = 1'b0;
      rst1 = 1'b0; cfg_valid1 = 1'b0; en1 = 1'b0;
      #1;
      check("post-rst cfg_ready", 32'(cfg_ready0), 32'h1);
      step();
      check("post-rst nothing accepted", 32'(cfg_ready0), 32'h1);

      // ---------------- Table-driven waveforms, SYNC_UPDATE=0 ----------------
      for (int t = 0; t < 6; t++) begin
         rst0 = 1'b1; en0 = 1'b0; cfg_valid0 = 1'b0;
         step(); step();
         rst0 = 1'b0;
         cfg_k0 = C_K1; cfg_p0 = vecs[t].p; cfg_mode0 = vecs[t].mode; cfg_valid0 = 1'b1;
         step();                                    // accept
         check($sformatf("v%0d ready after accept", t), 32'(cfg_ready0), 32'h0);
         cfg_valid0 = 1'b0;
         step();                                    // apply
         check($sformatf("v%0d ready after apply", t), 32'(cfg_ready0), 32'h1);
         en0 = 1'b1;
         step();                                    // first enabled edge
         check($sformatf("v%0d valid before latency", t), 32'(wave_valid0), 32'h0);
         for (int i = 0; i <= 16; i++) begin
            int         idx;
            logic [7:0] ew;
            logic       es;
            step();
            idx = i % 16;
            ew  = vecs[t].exp_wave[127-8*idx -: 8];
            es  = vecs[t].exp_sq[15-idx];
            check($sformatf("v%0d s%0d wave_out", t, i),   32'(wave_out0),   32'(ew));
            check($sformatf("v%0d s%0d sq_out", t, i),     32'(sq_out0),     32'(es));
            check($sformatf("v%0d s%0d wave_valid", t, i), 32'(wave_valid0), 32'h1);
            check($sformatf("v%0d s%0d wrap_pulse", t, i), 32'(wrap_pulse0), (i == 16) ? 32'h1 : 32'h0);
         end
         en0 = 1'b0;
      end

      // ---------------- SYNC_UPDATE=1: update deferred to wrap ----------------
      rst1 = 1'b1; step(); step(); rst1 = 1'b0;
      cfg_k1 = C_K1; cfg_p1 = '0; cfg_mode1 = 2'd1; cfg_valid1 = 1'b1;
      step();                                       // accept (en low)
      cfg_valid1 = 1'b0;
      step();                                       // applied since en is low
      check("sync initial apply ready", 32'(cfg_ready1), 32'h1);
      en1 = 1'b1;
      for (int n = 0; n < 30; n++) begin
         step();
         if (n >= 1) begin
            int         j;
            logic [7:0] ew;
            j  = n - 1;
            ew = (j < 16) ? 8'(16 * j) : 8'(32 * (j - 16));
            check($sformatf("sync n%0d wave_out", n),   32'(wave_out1),   32'(ew));
            check($sformatf("sync n%0d wrap_pulse", n), 32'(wrap_pulse1),
                  (j == 16 || j == 24) ? 32'h1 : 32'h0);
            check($sformatf("sync n%0d cfg_ready", n),  32'(cfg_ready1),
                  (n >= 3 && n <= 14) ? 32'h0 : 32'h1);
         end
         if (n == 2) begin
            cfg_k1 = C_K2; cfg_valid1 = 1'b1;       // offered while acc = 0x3000_0000
         end
         if (n == 3) begin
            cfg_valid1 = 1'b0; cfg_k1 = 32'h0700_0000;  // later changes ignored
         end
      end

      // ---------------- SYNC_UPDATE=1 with en low: applied next edge ----------------
      en1 = 1'b0;
      step();
      check("en0 last enabled sample", 32'(wave_out1),   32'hA0);
      check("en0 last enabled valid",  32'(wave_valid1), 32'h1);
      cfg_k1 = C_K1; cfg_valid1 = 1'b1;
      step();                                       // accept
      check("en0 ready after accept", 32'(cfg_ready1),  32'h0);
      check("en0 held sample",        32'(wave_out1),   32'hC0);
      check("en0 held valid",         32'(wave_valid1), 32'h0);
      cfg_valid1 = 1'b0;
      step();                                       // apply
      check("en0 ready after apply",  32'(cfg_ready1),  32'h1);
      check("en0 held valid 2",       32'(wave_valid1), 32'h0);
      en1 = 1'b1;
      step();
      step();
      check("en0 resume s0", 32'(wave_out1),   32'hC0);
      check("en0 resume v0", 32'(wave_valid1), 32'h1);
      step();
      check("en0 resume s1", 32'(wave_out1),   32'hD0);
      step();
      check("en0 resume s2", 32'(wave_out1),   32'hE0);

      // ---------------- Reset while a config is pending ----------------
      step();
      cfg_k1 = 32'h0400_0000; cfg_p1 = 11'h123; cfg_mode1 = 2'd2; cfg_valid1 = 1'b1;
      step();                                       // accept, waits for wrap
      cfg_valid1 = 1'b0;
      check("pend ready low", 32'(cfg_ready1), 32'h0);
      rst1 = 1'b1;
      step();
      check("pend rst ready",      32'(cfg_ready1),  32'h0);
      check("pend rst wave_out",   32'(wave_out1),   32'h0);
      check("pend rst wave_valid", 32'(wave_valid1), 32'h0);
      check("pend rst sq_out",     32'(sq_out1),     32'h0);
      check("pend rst wrap_pulse", 32'(wrap_pulse1), 32'h0);
      rst1 = 1'b0;
      #1;
      check("pend post-rst ready", 32'(cfg_ready1), 32'h1);
      for (int i = 0; i < 10; i++) begin
         step();
         // k_act=0, square mode, phase 0 -> constant all-ones sample
         check($sformatf("pend s%0d wave_out", i),   32'(wave_out1),   32'hFF);
         check($sformatf("pend s%0d sq_out", i),     32'(sq_out1),     32'h0);
         check($sformatf("pend s%0d wrap", i),       32'(wrap_pulse1), 32'h0);
         check($sformatf("pend s%0d wave_valid", i), 32'(wave_valid1), (i >= 1) ? 32'h1 : 32'h0);
         check($sformatf("pend s%0d cfg_ready", i),  32'(cfg_ready1),  32'h1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_dds_gen
`default_nettype wire
